// File: rtl/sha256_pkg.sv
// Shared types and constants for the SHA-256 round controller: state encoding,
// the 64 round constants K and the initial hash value IV.
package sha256_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ROUND = 2'd1,
    ST_FINAL = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam logic [5:0] ROUND_LAST = 6'd63;

  localparam logic [31:0] K [0:63] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
    32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
    32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
    32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
    32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
    32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
    32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
    32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
    32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  localparam logic [31:0] IV [0:7] = '{
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
  };

endpackage

// File: rtl/sha256_k_rom.sv
// Round-constant lookup: round index in, K[round] out, purely combinational.
module sha256_k_rom
  import sha256_pkg::*;
(
  input  logic [5:0]  round,
  output logic [31:0] k
);

  always_comb begin
    k = '0;
    case (round)
      6'd0:  k = K[0];   6'd1:  k = K[1];   6'd2:  k = K[2];   6'd3:  k = K[3];
      6'd4:  k = K[4];   6'd5:  k = K[5];   6'd6:  k = K[6];   6'd7:  k = K[7];
      6'd8:  k = K[8];   6'd9:  k = K[9];   6'd10: k = K[10];  6'd11: k = K[11];
      6'd12: k = K[12];  6'd13: k = K[13];  6'd14: k = K[14];  6'd15: k = K[15];
      6'd16: k = K[16];  6'd17: k = K[17];  6'd18: k = K[18];  6'd19: k = K[19];
      6'd20: k = K[20];  6'd21: k = K[21];  6'd22: k = K[22];  6'd23: k = K[23];
      6'd24: k = K[24];  6'd25: k = K[25];  6'd26: k = K[26];  6'd27: k = K[27];
      6'd28: k = K[28];  6'd29: k = K[29];  6'd30: k = K[30];  6'd31: k = K[31];
      6'd32: k = K[32];  6'd33: k = K[33];  6'd34: k = K[34];  6'd35: k = K[35];
      6'd36: k = K[36];  6'd37: k = K[37];  6'd38: k = K[38];  6'd39: k = K[39];
      6'd40: k = K[40];  6'd41: k = K[41];  6'd42: k = K[42];  6'd43: k = K[43];
      6'd44: k = K[44];  6'd45: k = K[45];  6'd46: k = K[46];  6'd47: k = K[47];
      6'd48: k = K[48];  6'd49: k = K[49];  6'd50: k = K[50];  6'd51: k = K[51];
      6'd52: k = K[52];  6'd53: k = K[53];  6'd54: k = K[54];  6'd55: k = K[55];
      6'd56: k = K[56];  6'd57: k = K[57];  6'd58: k = K[58];  6'd59: k = K[59];
      6'd60: k = K[60];  6'd61: k = K[61];  6'd62: k = K[62];  6'd63: k = K[63];
      default: k = '0;
    endcase
  end

endmodule

// File: rtl/sha256_round_ctrl.sv
// SHA-256 per-block compression sequencer with chaining and digest handshake.
// Optional SHA256_PERF_CNT_EN adds blk_cnt/busy_cyc performance counters.
//
// state    | meaning
// ---------+----------------------------------------------------------
// ST_IDLE  | blk_ready=1, waiting for a block; handshake pulses vars_ld
// ST_ROUND | round_en=1, round_o steps 0..63, msg_o held
// ST_FINAL | hash_upd=1 for one cycle; chain to IDLE or finish in DONE
// ST_DONE  | digest_valid=1 until digest_ready
module sha256_round_ctrl
  import sha256_pkg::*;
#(
  parameter int unsigned ROUNDS = 64,
  parameter int unsigned BLK_W  = 512
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [BLK_W-1:0]          blk_data,
  input  logic                      blk_valid,
  input  logic                      blk_first,
  input  logic                      blk_last,
  output logic                      blk_ready,
  input  logic                      abort,
  output logic [BLK_W-1:0]          msg_o,
  output logic [$clog2(ROUNDS)-1:0] round_o,
  output logic [31:0]               k_o,
  output logic                      vars_ld,
  output logic                      use_iv,
  output logic                      round_en,
  output logic                      hash_upd,
  output logic                      digest_valid,
  input  logic                      digest_ready
`ifdef SHA256_PERF_CNT_EN
  ,
  output logic [31:0]               blk_cnt,
  output logic [31:0]               busy_cyc
`endif
);

  state_t     state, state_nxt;
  logic [5:0] round_q;
  logic [BLK_W-1:0] msg_q;
  logic       last_q;
  logic       iv_q;
  logic       accept;
  logic       round_term;

  // abort blocks acceptance but blk_ready still reads 1 in IDLE
  assign accept     = (state == ST_IDLE) & blk_valid & ~abort;
  assign round_term = (round_q == ROUND_LAST);

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (accept) state_nxt = ST_ROUND;
      ST_ROUND: if (round_term) state_nxt = ST_FINAL;
      ST_FINAL: state_nxt = last_q ? ST_DONE : ST_IDLE;
      ST_DONE:  if (digest_ready) state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
    if (abort) state_nxt = ST_IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      round_q <= '0;
      msg_q   <= '0;
      last_q  <= 1'b0;
      iv_q    <= 1'b0;
    end else begin
      state <= state_nxt;
      if (abort) begin
        round_q <= '0;
        last_q  <= 1'b0;
        iv_q    <= 1'b0;
      end else if (accept) begin
        msg_q   <= blk_data;
        last_q  <= blk_last;
        iv_q    <= blk_first;
        round_q <= '0;
      end else if (state == ST_ROUND) begin
        // wraps to 0 on the last round so round_o idles at 0 outside ROUND
        round_q <= round_term ? 6'd0 : round_q + 6'd1;
      end
    end
  end

  sha256_k_rom u_k_rom (
    .round (round_q),
    .k     (k_o)
  );

  assign msg_o        = msg_q;
  assign round_o      = round_q;
  assign blk_ready    = (state == ST_IDLE);
  assign vars_ld      = accept;
  assign use_iv       = accept ? blk_first : iv_q;
  assign round_en     = (state == ST_ROUND);
  assign hash_upd     = (state == ST_FINAL) & ~abort;
  assign digest_valid = (state == ST_DONE);

`ifdef SHA256_PERF_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      blk_cnt  <= '0;
      busy_cyc <= '0;
    end else if (abort) begin
      blk_cnt  <= '0;
      busy_cyc <= '0;
    end else begin
      if (hash_upd) blk_cnt <= blk_cnt + 32'd1;
      if ((state == ST_ROUND) || (state == ST_FINAL)) busy_cyc <= busy_cyc + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_sha256_round_ctrl.sv
// Bench for sha256_round_ctrl: cycle-count model of the sequencing rules plus a
// bench-side SHA-256 datapath driven by the DUT strobes to reproduce known digests.
module tb_sha256_round_ctrl;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [511:0] blk_data;
  logic         blk_valid, blk_first, blk_last, abort, digest_ready;
  logic         blk_ready, vars_ld, use_iv, round_en, hash_upd, digest_valid;
  logic [511:0] msg_o;
  logic [5:0]   round_o;
  logic [31:0]  k_o;
`ifdef SHA256_PERF_CNT_EN
  logic [31:0]  blk_cnt, busy_cyc;
`endif

  sha256_round_ctrl dut (
    .clk(clk), .rst_n(rst_n), .blk_data(blk_data), .blk_valid(blk_valid),
    .blk_first(blk_first), .blk_last(blk_last), .blk_ready(blk_ready), .abort(abort),
    .msg_o(msg_o), .round_o(round_o), .k_o(k_o), .vars_ld(vars_ld), .use_iv(use_iv),
    .round_en(round_en), .hash_upd(hash_upd), .digest_valid(digest_valid),
    .digest_ready(digest_ready)
`ifdef SHA256_PERF_CNT_EN
    , .blk_cnt(blk_cnt), .busy_cyc(busy_cyc)
`endif
  );

  always #5 clk = ~clk;

  localparam logic [31:0] KT [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };
  localparam logic [31:0] IVT [8] = '{
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
  };

  localparam logic [511:0] ABC_BLK = {32'h61626380, {14{32'h00000000}}, 32'h00000018};
  localparam logic [255:0] ABC_DIG =
    256'hba7816bf_8f01cfea_414140de_5dae2223_b00361a3_96177a9c_b410ff61_f20015ad;
  localparam logic [511:0] TWO_B1 = {
    32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667, 32'h65666768, 32'h66676869,
    32'h6768696a, 32'h68696a6b, 32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
    32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000};
  localparam logic [511:0] TWO_B2 = {{15{32'h00000000}}, 32'h000001c0};
  localparam logic [255:0] TWO_DIG =
    256'h248d6a61_d20638b8_e5c02693_0c3e6039_a33ce459_64ff2167_f6ecedd4_19db06c1;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  int cyc = 0;
  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Cycle-count model: m_n counts cycles since the accepting handshake (0 = idle).
  int           m_n = 0;
  bit           m_done = 0, m_last = 0, m_iv = 0;
  logic [511:0] m_msg = '0;
  bit           exp_acc;
  int           exp_rnd;

  initial forever begin
    @(negedge clk);
    if (!rst_n) begin
      m_n = 0; m_done = 0; m_last = 0; m_iv = 0; m_msg = '0;
    end
    exp_acc = rst_n && (m_n == 0) && !m_done && blk_valid && !abort;
    exp_rnd = (m_n >= 1 && m_n <= 64) ? m_n - 1 : 0;
    chk("blk_ready", blk_ready, (m_n == 0) && !m_done);
    chk("vars_ld", vars_ld, exp_acc);
    chk("round_en", round_en, (m_n >= 1) && (m_n <= 64));
    chk("round_o", round_o, exp_rnd);
    chk("hash_upd", hash_upd, (m_n == 65) && !abort);
    chk("digest_valid", digest_valid, m_done);
    chk("msg_o", msg_o, m_msg);
    chk("k_o", k_o, KT[exp_rnd]);
    if (exp_acc) chk("use_iv_at_ld", use_iv, blk_first);
    if (m_n == 65) chk("use_iv_at_upd", use_iv, m_iv);
    if (rst_n) begin
      if (abort) begin
        m_n = 0; m_done = 0;
      end else if (exp_acc) begin
        m_n = 1; m_msg = blk_data; m_last = blk_last; m_iv = blk_first;
      end else if (m_n >= 1 && m_n <= 64) begin
        m_n++;
      end else if (m_n == 65) begin
        m_n = 0; m_done = m_last;
      end else if (m_done && digest_ready) begin
        m_done = 0;
      end
    end
  end

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  // Bench-side compression datapath plus event monitor.
  logic [31:0] hh [8];
  logic [31:0] vv [8];
  logic [31:0] ww [64];
  logic [31:0] kcap [64];
  logic [31:0] t1, t2, s0, s1;
  int  vl_cyc = -1, hash_cyc = -1, dv_rise_cyc = -1, dv_rises = 0, hash_cnt = 0;
  bit  vl_iv = 0, dv_prev = 0;

  initial forever begin
    @(negedge clk);
    if (rst_n) begin
      if (vars_ld) begin
        vl_cyc = cyc; vl_iv = use_iv;
        for (int i = 0; i < 8; i++) begin
          if (use_iv) hh[i] = IVT[i];
          vv[i] = hh[i];
        end
      end
      if (round_en) begin
        kcap[round_o] = k_o;
        if (round_o == 6'd0) begin
          for (int t = 0; t < 16; t++) ww[t] = msg_o[511 - 32*t -: 32];
          for (int t = 16; t < 64; t++) begin
            s0 = rotr(ww[t-15], 7) ^ rotr(ww[t-15], 18) ^ (ww[t-15] >> 3);
            s1 = rotr(ww[t-2], 17) ^ rotr(ww[t-2], 19) ^ (ww[t-2] >> 10);
            ww[t] = s1 + ww[t-7] + s0 + ww[t-16];
          end
        end
        t1 = vv[7] + (rotr(vv[4], 6) ^ rotr(vv[4], 11) ^ rotr(vv[4], 25))
           + ((vv[4] & vv[5]) ^ (~vv[4] & vv[6])) + k_o + ww[round_o];
        t2 = (rotr(vv[0], 2) ^ rotr(vv[0], 13) ^ rotr(vv[0], 22))
           + ((vv[0] & vv[1]) ^ (vv[0] & vv[2]) ^ (vv[1] & vv[2]));
        vv[7] = vv[6]; vv[6] = vv[5]; vv[5] = vv[4]; vv[4] = vv[3] + t1;
        vv[3] = vv[2]; vv[2] = vv[1]; vv[1] = vv[0]; vv[0] = t1 + t2;
      end
      if (hash_upd) begin
        hash_cyc = cyc; hash_cnt++;
        for (int i = 0; i < 8; i++) hh[i] = hh[i] + vv[i];
      end
      if (digest_valid && !dv_prev) begin
        dv_rise_cyc = cyc; dv_rises++;
      end
    end
    dv_prev = digest_valid;
  end

  function automatic logic [255:0] digest();
    return {hh[0], hh[1], hh[2], hh[3], hh[4], hh[5], hh[6], hh[7]};
  endfunction

  task automatic send(input logic [511:0] d, input bit f, input bit l, output int t);
    @(posedge clk); #1;
    blk_data = d; blk_first = f; blk_last = l; blk_valid = 1'b1;
    t = cyc;
    @(posedge clk); #1;
    // later input changes must be ignored by the controller
    blk_valid = 1'b0; blk_data = ~d; blk_first = ~f; blk_last = ~l;
  endtask

  task automatic wait_dv(input int limit);
    int k;
    k = 0;
    while (!digest_valid && k < limit) begin
      @(negedge clk);
      k++;
    end
    chk("digest_valid_timeout", digest_valid, 1'b1);
  endtask

  task automatic take_digest();
    @(posedge clk); #1 digest_ready = 1'b1;
    @(posedge clk); #1 digest_ready = 1'b0;
    @(negedge clk);
    chk("take_blk_ready", blk_ready, 1'b1);
    chk("take_digest_valid", digest_valid, 1'b0);
  endtask

  int  t0, t1c, t2c, hc0;
  bit  found;

  initial begin
    blk_data = '0; blk_valid = 0; blk_first = 0; blk_last = 0; abort = 0; digest_ready = 0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("rst_blk_ready", blk_ready, 1'b1);
    chk("rst_round_o", round_o, 6'd0);
    chk("rst_msg_o", msg_o, 512'd0);
    chk("rst_digest_valid", digest_valid, 1'b0);

    // single-block "abc": timing and digest
    send(ABC_BLK, 1'b1, 1'b1, t0);
    wait_dv(200);
    chk("t1_vars_ld_cyc", vl_cyc, t0);
    chk("t1_use_iv", vl_iv, 1'b1);
    chk("t1_hash_cyc", hash_cyc, t0 + 65);
    chk("t1_dv_cyc", dv_rise_cyc, t0 + 66);
    chk("t1_digest", digest(), ABC_DIG);
    chk("k_round0", kcap[0], 32'h428a2f98);
    chk("k_round15", kcap[15], 32'hc19bf174);
    chk("k_round63", kcap[63], 32'hc67178f2);
    take_digest();

    // async reset in the middle of a block
    send(ABC_BLK, 1'b1, 1'b1, t0);
    repeat (10) @(posedge clk);
    #1 rst_n = 1'b0;
    #2;
    chk("arst_round_o", round_o, 6'd0);
    chk("arst_round_en", round_en, 1'b0);
    chk("arst_blk_ready", blk_ready, 1'b1);
    chk("arst_msg_o", msg_o, 512'd0);
    @(posedge clk); #1 rst_n = 1'b1;
    dv_rises = 0; hash_cnt = 0;

    // two-block chained message
    send(TWO_B1, 1'b1, 1'b0, t1c);
    chk("t3_b1_use_iv", vl_iv, 1'b1);
    repeat (70) @(negedge clk);
    chk("t3_no_dv_after_b1", dv_rises, 0);
    chk("t3_hash_after_b1", hash_cnt, 1);
    send(TWO_B2, 1'b0, 1'b1, t2c);
    chk("t3_b2_use_iv", vl_iv, 1'b0);
    wait_dv(200);
    chk("t3_digest", digest(), TWO_DIG);
    chk("t3_dv_rises", dv_rises, 1);
`ifdef SHA256_PERF_CNT_EN
    chk("perf_blk_cnt", blk_cnt, 32'd2);
    chk("perf_busy_cyc", busy_cyc, 32'd130);
`endif

    // digest held while consumer stalls
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("t4_dv_held", digest_valid, 1'b1);
      chk("t4_blk_ready_low", blk_ready, 1'b0);
    end
    take_digest();

    // abort at round 20
    send(ABC_BLK, 1'b1, 1'b1, t0);
    found = 0;
    for (int i = 0; i < 100 && !found; i++) begin
      @(posedge clk); #1;
      if (round_o == 6'd20) found = 1;
    end
    chk("t5_reach_round20", found, 1'b1);
    abort = 1'b1;
    hc0 = hash_cnt;
    @(posedge clk); #1 abort = 1'b0;
    @(negedge clk);
    chk("t5_abort_round_o", round_o, 6'd0);
    chk("t5_abort_idle", blk_ready, 1'b1);
    chk("t5_abort_round_en", round_en, 1'b0);
    repeat (80) @(negedge clk);
    chk("t5_no_hash_upd", hash_cnt - hc0, 0);

    // abort coincident with a handshake attempt
    @(posedge clk); #1;
    abort = 1'b1; blk_valid = 1'b1; blk_data = TWO_B1; blk_first = 1'b1; blk_last = 1'b1;
    @(negedge clk);
    chk("t5_abort_vars_ld", vars_ld, 1'b0);
    chk("t5_abort_ready", blk_ready, 1'b1);
    @(posedge clk); #1 abort = 1'b0; blk_valid = 1'b0;
    @(negedge clk);
    chk("t5_abort_no_round", round_en, 1'b0);
    repeat (3) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
